// File: rtl/icache_axi_rd_bridge.sv
// icache refill / uncached-fetch responder: one request becomes one AXI4
// INCR read burst, returned beats stream back one word per data_valid pulse.
module icache_axi_rd_bridge #(
  parameter int ID_WIDTH = 4,
  parameter int AXI_ID   = 0,
  parameter int MAX_LEN  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  input  logic [31:0]         req_addr_i,
  input  logic [7:0]          req_len_i,
  output logic                resp_ready_o,
  output logic                data_valid_o,
  output logic [31:0]         data_o,
  output logic                busy_o,
  output logic                err_o,
  output logic [ID_WIDTH-1:0] arid_o,
  output logic [31:0]         araddr_o,
  output logic [7:0]          arlen_o,
  output logic [2:0]          arsize_o,
  output logic [1:0]          arburst_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [ID_WIDTH-1:0] rid_i,
  input  logic [31:0]         rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rlast_i,
  input  logic                rvalid_i,
  output logic                rready_o
);

  localparam logic [ID_WIDTH-1:0] ID_W = ID_WIDTH'(AXI_ID);
  localparam logic [7:0] MAX_W = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R_DATA,
    ZERO
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        resp_q, resp_d;
  logic        dv_q, dv_d;
  logic [31:0] data_q, data_d;

  logic req_fire;
  logic ar_fire;
  logic r_fire;
  logic last_exp;
  logic beat_err;

  assign req_fire = (state_q == IDLE) && req_valid_i;
  assign ar_fire  = (state_q == AR) && arready_i;
  assign r_fire   = (state_q == R_DATA) && rvalid_i;
  assign last_exp = cnt_q == (len_q - 8'd1);

  assign beat_err = (rresp_i != 2'b00)
                 || (rid_i != ID_W)
                 || (rlast_i && (cnt_q < (len_q - 8'd1)))
                 || (!rlast_i && last_exp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      resp_q  <= 1'b0;
      dv_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = (req_len_i == 8'd0) ? ZERO : AR;
        end
      end
      AR: begin
        if (arready_i) state_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid_i && rlast_i) state_d = IDLE;
      end
      ZERO: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    resp_d = 1'b0;
    dv_d   = 1'b0;
    data_d = data_q;
    if (req_fire) begin
      addr_d = req_addr_i & 32'hFFFF_FFFC;
      if (req_len_i > MAX_W) begin
        len_d = MAX_W;
        err_d = 1'b1;
      end else begin
        len_d = req_len_i;
      end
      resp_d = (req_len_i == 8'd0);
    end
    if (ar_fire) begin
      resp_d = 1'b1;
      cnt_d  = '0;
    end
    // beats past len are drained but not forwarded
    if (r_fire) begin
      if (cnt_q < len_q) begin
        dv_d   = 1'b1;
        data_d = rdata_i;
      end
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      if (beat_err) err_d = 1'b1;
    end
  end

  always_comb begin
    arvalid_o    = (state_q == AR);
    araddr_o     = arvalid_o ? addr_q : '0;
    arlen_o      = arvalid_o ? (len_q - 8'd1) : '0;
    arsize_o     = arvalid_o ? 3'b010 : '0;
    arburst_o    = arvalid_o ? 2'b01 : '0;
    arid_o       = arvalid_o ? ID_W : '0;
    rready_o     = (state_q == R_DATA);
    busy_o       = (state_q != IDLE);
    resp_ready_o = resp_q;
    data_valid_o = dv_q;
    data_o       = data_q;
    err_o        = err_q;
  end

endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
- Memory-side responder for the icache refill/uncached-fetch request interface (addr_valid / addr / data_len → resp_ready, data_valid / data).
- Captures a single-cycle request pulse and issues it as one AXI4 INCR read burst.
- Streams the returned beats back one 32-bit word per data_valid pulse.
- Sits between the icache and the AXI interconnect/arbiter.

Parameters:
- ID_WIDTH, 4, width of AXI arid/rid.
- AXI_ID, 0, fixed ID driven on arid and expected on rid.
- MAX_LEN, 8, largest legal req_len_i in words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request pulse from icache (its addr_valid_o)
- req_addr_i  in  32  physical byte address
- req_len_i  in  8  word count
- resp_ready_o  out  1  one-cycle pulse: request accepted by AXI
- data_valid_o  out  1  one-cycle pulse per returned word
- data_o  out  32  returned word
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky protocol/response error flag
- arid_o  out  ID_WIDTH  AXI read ID
- araddr_o  out  32  AXI read address
- arlen_o  out  8  AXI burst length
- arsize_o  out  3  AXI transfer size
- arburst_o  out  2  AXI burst type
- arvalid_o  out  1  AXI AR valid
- arready_i  in  1  AXI AR ready
- rid_i  in  ID_WIDTH  AXI read ID
- rdata_i  in  32  AXI read data
- rresp_i  in  2  AXI read response
- rlast_i  in  1  AXI last beat
- rvalid_i  in  1  AXI R valid
- rready_o  out  1  AXI R ready

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - state=IDLE.
  - All outputs 0, including err_o; data_o=0.
  - Beat counter and latched request cleared.
  - Applies mid-burst: the burst is abandoned with no completion; leftover R beats after reset are accepted only in R_DATA.
- States: IDLE, AR, R_DATA, ZERO.
- IDLE:
  - req_valid_i=1 latches addr & 32'hFFFF_FFFC and len.
  - len==0 → ZERO. len in 1..MAX_LEN → AR.
  - len>MAX_LEN → clamp len to MAX_LEN, set err_o, → AR.
- AR:
  - arvalid_o=1 and all AR fields are registered: araddr_o=latched addr, arlen_o=len-1, arsize_o=3'b010, arburst_o=2'b01, arid_o=AXI_ID.
  - Fields are held stable until arready_i.
  - On arvalid_o&arready_i at edge A: arvalid_o=0 and resp_ready_o=1 in cycle A+1, state=R_DATA, beat counter=0.
- ZERO:
  - resp_ready_o=1 for exactly one cycle, no AXI traffic, → IDLE.
- R_DATA:
  - rready_o=1.
  - Each rvalid_i&rready_o beat at edge B gives data_valid_o=1 and data_o=rdata_i in cycle B+1 (registered; data_o holds its value afterwards). The counter increments.
  - err_o set if rresp_i!=0, rid_i!=AXI_ID, rlast_i=1 before count==len-1, or rlast_i=0 on beat len-1.
  - Erroneous-response data is still forwarded.
  - Transaction ends on the beat with rlast_i=1: → IDLE, and data_valid_o for that beat appears in the first IDLE cycle.
  - Beats beyond len before rlast are accepted (rready stays 1) but not forwarded.
- Ordering guarantee: resp_ready_o always precedes the first data_valid_o by ≥1 cycle. Number of data_valid_o pulses = min(len, beats up to rlast).
- Back-to-back: a req_valid_i in the IDLE cycle that carries the final data_valid_o is accepted.
- req_valid_i while busy_o=1 is ignored, with no state effect.
- resp_ready_o and data_valid_o are never high in the same cycle.
- err_o clears only on reset.

Test Plan:
- Cache-line miss: req addr=0x1C00_0044, len=8; arready after 2 cycles; 8 beats 0xA0..0xA7 with rlast on the 8th → araddr=0x1C00_0044, arlen=7, arsize=2, arburst=1; one resp_ready pulse; 8 data_valid pulses 0xA0..0xA7 in order; err_o=0; busy_o low after the last one.
- Uncached single fetch: addr=0x0000_1006, len=1 → araddr=0x0000_1004, arlen=0; one data_valid; gapped rvalid (bubbles between beats) for a len=2 request also yields exactly 2 pulses.
- len=0 → no arvalid ever; resp_ready high exactly 1 cycle after the request; returns to IDLE; no data_valid.
- Error paths:
  - rresp=2'b10 on beat 3 of 8 → all 8 words forwarded, err_o=1 sticky.
  - Separate run with rlast on beat 5 of len=8 → 5 data_valid pulses, err_o=1, IDLE.
  - len=12 → arlen=7, err_o=1.
- Busy and back-to-back: req_valid during R_DATA ignored (no second AR); a new request in the final-data cycle issues a new arvalid on the next cycle.
- Reset mid-burst after 3 beats → all outputs 0 next cycle; subsequent fresh request completes normally.
